// File: rtl/sipo_deser_if.sv
// Serial intake and word-output handshake bundle for sipo_deser.
// The slave modport is the deserialiser side; master is the line/consumer side.
interface sipo_deser_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  serial_in;
  logic                  serial_valid;
  logic                  frame_start;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] parallel_out;
  logic                  out_valid;
  logic [CNT_W-1:0]      bit_count;
  logic                  overrun;

  modport master (
    output serial_in, serial_valid, frame_start, out_ready,
    input  parallel_out, out_valid, bit_count, overrun
  );

  modport slave (
    input  serial_in, serial_valid, frame_start, out_ready,
    output parallel_out, out_valid, bit_count, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with frame restart, held output word,
// valid/ready handshake and a one-cycle overrun pulse.
module sipo_deser #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b0
) (
  input logic       clk,
  input logic       reset,
  sipo_deser_if.slave bus
);
  localparam int               CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_base;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_base;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  valid_q;
  logic                  overrun_q;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic                  b);
    if (LSB_FIRST)
      return {b, w[DATA_WIDTH-1:1]};
    else
      return {w[DATA_WIDTH-2:0], b};
  endfunction

  // frame_start restarts from an empty word, so the sampled bit becomes bit 0
  always_comb begin
    shreg_base = bus.frame_start ? '0 : shreg;
    cnt_base   = bus.frame_start ? '0 : cnt;
    shreg_nxt  = shift_in(shreg_base, bus.serial_in);
    word_done  = bus.serial_valid && (cnt_base == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (bus.serial_valid) begin
      shreg <= shreg_nxt;
      cnt   <= word_done ? '0 : cnt_base + CNT_W'(1);
    end
  end

  // Output register: a completing word always wins, even over an unaccepted one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= word_done && valid_q && !bus.out_ready;
      if (word_done) begin
        word_q  <= shreg_nxt;
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.parallel_out = word_q;
  assign bus.out_valid    = valid_q;
  assign bus.bit_count    = cnt;
  assign bus.overrun      = overrun_q;
endmodule
